// File: rtl/div_seq_controller_pkg.sv
// Shared definitions for the 10-bit restoring divider: state codes, iteration
// default and datapath widths used by the controller and the datapath.
package div_seq_controller_pkg;

  localparam int ITERATIONS_DEFAULT = 10;
  localparam int QUOT_W             = 10;
  localparam int REM_W              = 11;
  localparam int CNT_W              = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TEST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/div_seq_controller.sv
// Sequencer for the restoring divider: INIT, ITERATIONS x (SHIFT, TEST), DONE -> 2*ITERATIONS+2 cycles.
// No backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module div_seq_controller
  import div_seq_controller_pkg::*;
#(
  parameter int               ITERATIONS = ITERATIONS_DEFAULT,
  parameter logic [CNT_W-1:0] CNT_INIT   = CNT_W'(16 - ITERATIONS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             divisor_zero,
  input  logic             rem_lt,
  input  logic             cnt_carry,
  output logic             busy,
  output logic             done,
  output logic             dz_error,
  output logic             ld_operands,
  output logic             ld_rem,
  output logic             rem_sel,
  output logic             shift_q,
  output logic             set_q0,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic [CNT_W-1:0] cnt_init
);

  state_t state;

  assign cnt_init = CNT_INIT;

  // busy/done/dz_error are registered next to the state so they carry no glitches
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dz_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_INIT;
            busy     <= 1'b1;
            dz_error <= 1'b0;
          end
        end
        ST_INIT: begin
          if (divisor_zero) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            dz_error <= 1'b1;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          state <= ST_TEST;
        end
        ST_TEST: begin
          // carry reflects the count before this cycle's increment
          if (cnt_carry) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ld_operands = 1'b0;
    ld_rem      = 1'b0;
    rem_sel     = 1'b0;
    shift_q     = 1'b0;
    set_q0      = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      ST_INIT: begin
        ld_operands = 1'b1;
        cnt_load    = 1'b1;
      end
      ST_SHIFT: begin
        ld_rem  = 1'b1;
        shift_q = 1'b1;
      end
      ST_TEST: begin
        cnt_en = 1'b1;
        // restore by simply not loading when the trial subtraction would go negative
        if (!rem_lt) begin
          ld_rem  = 1'b1;
          rem_sel = 1'b1;
          set_q0  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_seq_controller.sv
// Directed bench for div_seq_controller with a behavioural restoring-division datapath attached.
module tb_div_seq_controller;
  import div_seq_controller_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             divisor_zero;
  logic             rem_lt;
  logic             cnt_carry;
  logic             busy, done, dz_error;
  logic             ld_operands, ld_rem, rem_sel, shift_q, set_q0, cnt_load, cnt_en;
  logic [CNT_W-1:0] cnt_init;

  logic [QUOT_W-1:0] dividend_in = '0;
  logic [QUOT_W-1:0] divisor_in  = 10'd1;
  logic [REM_W-1:0]  m_rem = '0;
  logic [QUOT_W-1:0] m_dvs = '0;
  logic [QUOT_W-1:0] m_q   = '0;
  logic [CNT_W-1:0]  m_cnt = '0;
  logic [6:0]        strobes;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  div_seq_controller dut (
    .clock(clock), .reset(reset), .start(start), .divisor_zero(divisor_zero),
    .rem_lt(rem_lt), .cnt_carry(cnt_carry), .busy(busy), .done(done),
    .dz_error(dz_error), .ld_operands(ld_operands), .ld_rem(ld_rem),
    .rem_sel(rem_sel), .shift_q(shift_q), .set_q0(set_q0),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_init(cnt_init)
  );

  assign strobes      = {ld_operands, ld_rem, rem_sel, shift_q, set_q0, cnt_load, cnt_en};
  assign divisor_zero = (divisor_in == '0);
  assign rem_lt       = (m_rem < {1'b0, m_dvs});
  assign cnt_carry    = (m_cnt == 4'd15);

  // Datapath: remainder, divisor, quotient/dividend shift register and iteration counter
  always @(posedge clock) begin
    if (ld_operands) begin
      m_dvs <= divisor_in;
      m_q   <= dividend_in;
      m_rem <= '0;
    end
    if (ld_rem) m_rem <= rem_sel ? (m_rem - {1'b0, m_dvs}) : {m_rem[QUOT_W-1:0], m_q[QUOT_W-1]};
    if (shift_q) m_q <= {m_q[QUOT_W-2:0], 1'b0};
    else if (set_q0) m_q[0] <= 1'b1;
    if (cnt_load) m_cnt <= cnt_init;
    else if (cnt_en) m_cnt <= m_cnt + 4'd1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (dz_error !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", dz_error); end
    total++; if (strobes !== 7'b0) begin bad++; $display("FAIL reset_strobes got=%b want=0000000", strobes); end
    total++; if (cnt_init !== 4'd6) begin bad++; $display("FAIL reset_cnt_init got=%0d want=6", cnt_init); end
    start = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal();
    int shifts = 0, tests = 0, done_n = 0, done_cyc = 0, busy_bad = 0, overlap = 0;
    dividend_in = 10'd1000;
    divisor_in  = 10'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 1) begin
        total++; if (strobes !== 7'b1000010) begin bad++; $display("FAIL normal_init_strobes got=%b want=1000010", strobes); end
      end
      if (shift_q) shifts++;
      if (cnt_en) tests++;
      if (shift_q && cnt_en) overlap++;
      if (done) begin done_n++; done_cyc = c; end
      if (busy !== (c <= 22)) busy_bad++;
      if (c == 22) begin
        total++; if (m_q !== 10'd333) begin bad++; $display("FAIL normal_quot got=%0d want=333", m_q); end
        total++; if (m_rem !== 11'd1) begin bad++; $display("FAIL normal_rem got=%0d want=1", m_rem); end
      end
      step();
    end
    total++; if (shifts != 10) begin bad++; $display("FAIL normal_shifts got=%0d want=10", shifts); end
    total++; if (tests != 10) begin bad++; $display("FAIL normal_tests got=%0d want=10", tests); end
    total++; if (overlap != 0) begin bad++; $display("FAIL normal_overlap got=%0d want=0", overlap); end
    total++; if (done_n != 1 || done_cyc != 22) begin bad++; $display("FAIL normal_done count=%0d cycle=%0d want count=1 cycle=22", done_n, done_cyc); end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL normal_busy bad_cycles=%0d want=0", busy_bad); end
  endtask

  task automatic test_full_system();
    int iter = 0, done_seen = 0;
    logic [15:0] mask = '0;
    dividend_in = 10'd100;
    divisor_in  = 10'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (shift_q) iter++;
      if (cnt_en && set_q0) mask[iter] = 1'b1;
      if (done) begin
        done_seen++;
        total++; if (m_q !== 10'd14) begin bad++; $display("FAIL full_quot got=%0d want=14", m_q); end
        total++; if (m_rem !== 11'd2) begin bad++; $display("FAIL full_rem got=%0d want=2", m_rem); end
      end
      step();
    end
    total++; if (done_seen != 1) begin bad++; $display("FAIL full_done_seen got=%0d want=1", done_seen); end
    total++; if (mask !== 16'h0380) begin bad++; $display("FAIL full_setq0_iters got=%h want=0380", mask); end
  endtask

  task automatic test_div_zero();
    int strobe_hits = 0, done_n = 0;
    dividend_in = 10'd55;
    divisor_in  = 10'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (ld_operands !== 1'b1 || dz_error !== 1'b0) begin bad++; $display("FAIL dz_init ld_operands=%b dz=%b want 1/0", ld_operands, dz_error); end
    step();
    total++; if ({busy, done, dz_error} !== 3'b111) begin bad++; $display("FAIL dz_done busy/done/dz=%b want=111", {busy, done, dz_error}); end
    total++; if (strobes !== 7'b0) begin bad++; $display("FAIL dz_done_strobes got=%b want=0000000", strobes); end
    for (int c = 0; c < 6; c++) begin
      step();
      if (strobes !== 7'b0 || busy !== 1'b0) strobe_hits++;
    end
    total++; if (strobe_hits != 0) begin bad++; $display("FAIL dz_quiet active_cycles=%0d want=0", strobe_hits); end
    total++; if (dz_error !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b want=1", dz_error); end
    dividend_in = 10'd20;
    divisor_in  = 10'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (dz_error !== 1'b0 || ld_operands !== 1'b1) begin bad++; $display("FAIL dz_clear dz=%b ld_operands=%b want 0/1", dz_error, ld_operands); end
    for (int c = 1; c <= 24; c++) begin
      if (done) begin
        done_n++;
        total++; if (m_q !== 10'd4 || m_rem !== 11'd0) begin bad++; $display("FAIL dz_followup q=%0d r=%0d want 4/0", m_q, m_rem); end
      end
      step();
    end
    total++; if (done_n != 1) begin bad++; $display("FAIL dz_followup_done got=%0d want=1", done_n); end
  endtask

  task automatic test_start_busy();
    int done_n = 0, init_n = 0, late_busy = 0;
    dividend_in = 10'd500;
    divisor_in  = 10'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (ld_operands) init_n++;
      if (done) begin
        done_n++;
        total++; if (m_q !== 10'd55 || m_rem !== 11'd5) begin bad++; $display("FAIL busy_result q=%0d r=%0d want 55/5", m_q, m_rem); end
      end
      if (c >= 23 && busy !== 1'b0) late_busy++;
      start = (c == 5 || c == 22);
      step();
    end
    start = 1'b0;
    total++; if (done_n != 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", done_n); end
    total++; if (init_n != 1) begin bad++; $display("FAIL busy_init_count got=%0d want=1", init_n); end
    total++; if (late_busy != 0) begin bad++; $display("FAIL busy_after_done cycles=%0d want=0", late_busy); end
  endtask

  task automatic test_back_to_back();
    int init_n = 0, done_n = 0, idle_ok = 0;
    int init_cyc[3] = '{0, 0, 0};
    int done_cyc[2] = '{0, 0};
    dividend_in = 10'd77;
    divisor_in  = 10'd77;
    start = 1'b1;
    step();
    for (int c = 1; c <= 50; c++) begin
      if (ld_operands) begin if (init_n < 3) init_cyc[init_n] = c; init_n++; end
      if (done) begin if (done_n < 2) done_cyc[done_n] = c; done_n++; end
      step();
    end
    start = 1'b0;
    total++; if (init_n != 3 || init_cyc[0] != 1 || init_cyc[1] != 24 || init_cyc[2] != 47) begin
      bad++; $display("FAIL b2b_init n=%0d cycles=%0d,%0d,%0d want 3: 1,24,47", init_n, init_cyc[0], init_cyc[1], init_cyc[2]);
    end
    total++; if (done_n != 2 || done_cyc[0] != 22 || done_cyc[1] != 45) begin
      bad++; $display("FAIL b2b_done n=%0d cycles=%0d,%0d want 2: 22,45", done_n, done_cyc[0], done_cyc[1]);
    end
    for (int c = 0; c < 30; c++) begin
      if (!busy) begin idle_ok = 1; break; end
      step();
    end
    total++; if (idle_ok != 1) begin bad++; $display("FAIL b2b_drain busy=%b want=0 within 30 cycles", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    int tests = 0, hit_cyc = 0;
    dividend_in = 10'd100;
    divisor_in  = 10'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (cnt_en) tests++;
      if (tests == 5) begin hit_cyc = c; break; end
      step();
    end
    total++; if (hit_cyc != 11) begin bad++; $display("FAIL mid_test5_cycle got=%0d want=11", hit_cyc); end
    reset = 1'b1;
    step();
    total++; if ({busy, done, dz_error} !== 3'b000) begin bad++; $display("FAIL mid_reset_flags busy/done/dz=%b want=000", {busy, done, dz_error}); end
    total++; if (strobes !== 7'b0) begin bad++; $display("FAIL mid_reset_strobes got=%b want=0000000", strobes); end
    reset = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b0 || strobes !== 7'b0) begin bad++; $display("FAIL mid_no_resume busy=%b strobes=%b want 0/0000000", busy, strobes); end
  endtask

  initial begin
    dividend_in = '0;
    divisor_in  = 10'd1;
    test_reset();
    test_normal();
    test_full_system();
    test_div_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq_controller.md
Name: div_seq_controller

Overview:
- Moore-style FSM that sequences the 10-bit restoring-division datapath. That datapath is an 11-bit remainder register, a 10-bit divisor register and a 10-bit quotient register. It also contains an 11-bit subtractor, an 11-bit comparator, a 2:1 remainder mux and a 4-bit iteration counter.
- Accepts a start request and issues per-cycle load, select and shift strobes to that datapath.
- Uses the counter carry to terminate the iterations.
- Reports busy, a one-cycle done pulse, and a sticky divide-by-zero error.

Parameters:
- ITERATIONS, 10, quotient bits produced; legal range 1..16.
- CNT_INIT, 16-ITERATIONS, value loaded into the 4-bit counter so that its carry (count==15) marks the last iteration.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- divisor_zero  in  1  divisor register operand == 0 (valid in INIT)
- rem_lt  in  1  comparator lt: shifted remainder < divisor
- cnt_carry  in  1  counter carryO
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- dz_error  out  1  sticky; set on divide-by-zero, cleared on accepted start
- ld_operands  out  1  load divisor and dividend registers, clear remainder
- ld_rem  out  1  load remainder register from mux
- rem_sel  out  1  mux select: 0 = shifted {rem[9:0],q[9]}, 1 = subtractor result
- shift_q  out  1  shift quotient left, inserting 0
- set_q0  out  1  force quotient bit 0 to 1
- cnt_load  out  1  load counter with cnt_init
- cnt_en  out  1  increment counter
- cnt_init  out  4  constant CNT_INIT

Behaviour:
- Reset: state=IDLE. Every output is 0 except cnt_init, which is constant. Reset wins over all other inputs, including mid-division; a partial result is abandoned.
- States: IDLE, INIT, SHIFT, TEST, DONE. Encoding is a 3-bit constant.
- IDLE: all strobes 0. If start=1, go to INIT and clear dz_error on that edge.
- INIT (1 cycle): ld_operands=1, cnt_load=1.
  - If divisor_zero=1, set dz_error and go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: ld_rem=1, rem_sel=0, shift_q=1. Always go to TEST.
- TEST: cnt_en=1.
  - If rem_lt=0: ld_rem=1, rem_sel=1, set_q0=1.
  - If rem_lt=1: ld_rem=0 and the remainder is kept.
  - If cnt_carry=1 (sampled before the increment), go to DONE. Otherwise go to SHIFT.
- DONE (1 cycle): done=1, busy=1. Go to IDLE.
- Latency: start accepted on edge 0. The state sequence is INIT at cycle 1, then ITERATIONS × (SHIFT, TEST), then DONE at cycle 2·ITERATIONS+2 (22 for the default). The result is valid in the datapath registers from the DONE cycle on.
- Divide-by-zero: DONE at cycle 2 with dz_error=1. No SHIFT or TEST strobes are issued.
- start while busy: ignored, not queued. start asserted in the DONE cycle is also ignored.
- Back-to-back: start held high across the return to IDLE begins a new division on the next edge.
- Strobes are decoded combinationally from state and inputs only, with no extra register stage. ld_rem and shift_q are never both driven from TEST.
- Outputs never go X after reset, for any input values.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=0, INIT=1, SHIFT=2, TEST=3, DONE=4;
  - the ITERATIONS default;
  - the data widths 10 and 11.
- No sub-module; the FSM is a single block.
- The top-level divider instantiates this controller alongside the datapath components.

Test Plan:
- Reset mid-TEST: assert reset during iteration 5 -> next cycle state=IDLE, busy=0, every strobe 0, dz_error=0.
- Normal run: start pulse, divisor_zero=0, cnt_carry driven by a model counter loaded with 6 ->
  - exactly 10 SHIFT/TEST pairs;
  - done high only at cycle 22;
  - busy high for cycles 1-22.
- Full system, 100/7 with the datapath attached -> quotient 14 and remainder 2 at done; set_q0 asserted in the TEST cycles of iterations 7, 8 and 9.
- Divide-by-zero: divisor_zero=1 in INIT -> done at cycle 2, dz_error=1 and held; next start clears it on the accept edge.
- Start during busy: pulse start at cycles 5 and 22 -> no effect, and the done count stays 1.
- Start held constantly high -> a new INIT follows each DONE->IDLE with a 1-cycle gap, so runs repeat with a period of 23 cycles.
